imem_fetch_responder: RTL and testbench

- Instruction-memory responder serving the fetch side of the RV32I single-cycle core.
- Accepts a byte address from the program-counter / fetch initiator over a valid/ready request channel.
- Waits a programmable number of wait states, then returns the 32-bit instruction word over a valid/ready response channel.
- Includes a word-write load port so benches and a boot loader can fill program memory.

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_array.sv | 46 ++++
 rtl/imem_fetch_responder.sv | 116 +++++++++++
 tb/tb_imem_fetch_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory fetch responder.
// Holds the FSM state encoding, the NOP filler word and address checks.
package imem_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} imem_state_t;

  // Fetch addresses must be word aligned and inside the array.
  function automatic logic addr_bad(input logic [XLEN-1:0] addr, input int unsigned depth_words);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[XLEN-1:2]} >= depth_words);
  endfunction

  function automatic logic word_in_range(input logic [XLEN-1:0] addr, input int unsigned depth_words);
    return {2'b00, addr[XLEN-1:2]} < depth_words;
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH_WORDS x 32 program storage: one synchronous write port and one
// registered read port sampled on rd_en, returning the pre-write word on collision.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_idx,
  input  logic [XLEN-1:0] wr_data,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q, rdata_d;

  // Storage itself is never reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = mem[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rd_data = rdata_q;

endmodule

// File: rtl/imem_fetch_responder.sv
// Instruction fetch responder: accepts a PC over valid/ready, waits WAIT_STATES
// cycles, then holds the instruction word (or NOP + error) until resp_ready.
module imem_fetch_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_instr,
  output logic            resp_err,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_addr,
  input  logic [XLEN-1:0] load_data
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  imem_state_t     state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            resp_err_q, resp_err_d;
  logic            sample;
  logic            rd_en;
  logic [XLEN-1:0] rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            wr_en;
  logic            unused_load_lsbs;

  assign unused_load_lsbs = ^load_addr[1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    resp_err_d = resp_err_q;
    sample     = 1'b0;
    rd_en      = 1'b0;
    // With zero wait states the word is read on the accept edge itself.
    rd_addr    = (state_q == IDLE) ? req_addr : addr_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            sample  = 1'b1;
          end else begin
            cnt_d   = 4'(WAIT_STATES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          sample  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (sample) begin
      resp_err_d = addr_bad(rd_addr, DEPTH_WORDS);
      rd_en      = !resp_err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      resp_err_q <= resp_err_d;
    end
  end

  assign wr_en = load_en && word_in_range(load_addr, DEPTH_WORDS);

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_idx  (load_addr[AW+1:2]),
    .wr_data (load_data),
    .rd_en   (rd_en),
    .rd_idx  (rd_addr[AW+1:2]),
    .rd_data (rd_data)
  );

  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_err_q;
  assign resp_instr = resp_err_q ? NOP_INSTR : rd_data;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: a 2-wait-state instance for most scenarios
// and a 0-wait-state instance for the streaming case.
module tb_imem_fetch_responder;

  localparam int          WS_A     = 2;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_ready, resp_valid, resp_ready, resp_err, load_en;
  logic [31:0] req_addr, resp_instr, load_addr, load_data;
  logic b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_err, b_load_en;
  logic [31:0] b_req_addr, b_resp_instr, b_load_addr, b_load_data;

  exp_t        sb[$];
  logic [31:0] model[256];
  logic [31:0] model_b[3];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_fetch_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS_A)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_instr(resp_instr), .resp_err(resp_err),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  imem_fetch_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_instr(b_resp_instr), .resp_err(b_resp_err),
    .load_en(b_load_en), .load_addr(b_load_addr), .load_data(b_load_data)
  );

  function automatic exp_t expect_a(input logic [31:0] a);
    exp_t e;
    if (a[1:0] != 2'b00 || a[31:10] != 22'd0) begin
      e.instr = NOP_WORD;
      e.err   = 1'b1;
    end else begin
      e.instr = model[a[9:2]];
      e.err   = 1'b0;
    end
    return e;
  endfunction

  task automatic load_a(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
    if (a[31:10] == 22'd0) model[a[9:2]] = d;
  endtask

  // load_at: 0 none, N = drive a load to the same word N negedges after the accept edge.
  task automatic fetch_a(input logic [31:0] a, input int hold, input int load_at,
                         input logic [31:0] ld, input string tag);
    exp_t e;
    int   cycles;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL %s req_ready: got %b want 1", tag, req_ready);
    end
    req_valid = 1'b1; req_addr = a; resp_ready = (hold == 0);
    if (load_at == 1) model[a[9:2]] = ld;
    sb.push_back(expect_a(a));
    if (load_at == 2) model[a[9:2]] = ld;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; cycles = 1;
    load_en = (load_at == 1); load_addr = a; load_data = ld;
    while (resp_valid !== 1'b1 && cycles < 20) begin
      @(negedge clk);
      cycles++;
      load_en = (load_at == cycles);
    end
    load_en = 1'b0;
    checks++;
    if (cycles != WS_A + 1) begin
      errors++; $display("FAIL %s latency: got %0d cycles want %0d", tag, cycles, WS_A + 1);
    end
    e = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_instr !== e.instr || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: valid=%b instr=%h req_ready=%b want 1 %h 0",
                 tag, i, resp_valid, resp_instr, req_ready, e.instr);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    checks++;
    if (resp_instr !== e.instr || resp_err !== e.err) begin
      errors++;
      $display("FAIL %s data: got %h err=%b want %h err=%b", tag, resp_instr, resp_err, e.instr, e.err);
    end
    if (hold > 0) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++;
        $display("FAIL %s release: valid=%b req_ready=%b want 0 1", tag, resp_valid, req_ready);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_instr !== 32'd0 || resp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_a: ready=%b valid=%b instr=%h err=%b want 0 0 0 0",
               req_ready, resp_valid, resp_instr, resp_err);
    end
    checks++;
    if (b_req_ready !== 1'b0 || b_resp_valid !== 1'b0 || b_resp_instr !== 32'd0) begin
      errors++;
      $display("FAIL reset_b: ready=%b valid=%b instr=%h want 0 0 0", b_req_ready, b_resp_valid, b_resp_instr);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_load_fetch();
    load_a(32'h0, 32'h0050_0093);
    load_a(32'h4, 32'h0000_0113);
    fetch_a(32'h0, 0, 0, 32'h0, "fetch0");
    fetch_a(32'h4, 0, 0, 32'h0, "fetch4");
  endtask

  task automatic test_backpressure();
    fetch_a(32'h0, 5, 0, 32'h0, "backpressure");
  endtask

  task automatic test_errors();
    load_a(32'h3FC, 32'h00A0_0513);
    load_a(32'h400, 32'hBAD0_0BAD);
    fetch_a(32'h2, 0, 0, 32'h0, "misaligned");
    fetch_a(32'h400, 0, 0, 32'h0, "out_of_range");
    fetch_a(32'h3FC, 0, 0, 32'h0, "last_word");
    fetch_a(32'h0, 0, 0, 32'h0, "no_alias");
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h4; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL abort_in_reset: valid=%b ready=%b want 0 0", resp_valid, req_ready);
    end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || (i == 0 && req_ready !== 1'b1)) begin
        errors++; $display("FAIL abort_quiet%0d: valid=%b ready=%b want 0 1", i, resp_valid, req_ready);
      end
    end
    fetch_a(32'h4, 0, 0, 32'h0, "after_abort");
  endtask

  task automatic test_collision();
    load_a(32'h8, 32'h1111_1111);
    fetch_a(32'h8, 0, 2, 32'hDEAD_BEEF, "coll_entry_edge");
    fetch_a(32'h8, 0, 0, 32'h0, "coll_written");
    load_a(32'h8, 32'h2222_2222);
    fetch_a(32'h8, 0, 1, 32'hDEAD_BEEF, "coll_in_wait");
  endtask

  task automatic test_zero_wait();
    exp_t e;
    int   t_acc;
    int   t_prev;
    t_prev = 0;
    for (int k = 0; k < 3; k++) begin
      model_b[k] = $urandom;
      @(negedge clk);
      b_load_en = 1'b1; b_load_addr = 32'(4 * k); b_load_data = model_b[k];
    end
    @(negedge clk);
    b_load_en = 1'b0; b_resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (b_req_ready !== 1'b1) begin
        errors++; $display("FAIL zw%0d req_ready: got %b want 1", k, b_req_ready);
      end
      b_req_valid = 1'b1; b_req_addr = 32'(4 * k);
      sb.push_back({model_b[k], 1'b0});
      t_acc = cyc;
      if (k > 0) begin
        checks++;
        if (t_acc - t_prev != 2) begin
          errors++; $display("FAIL zw%0d spacing: got %0d cycles want 2", k, t_acc - t_prev);
        end
      end
      t_prev = t_acc;
      @(negedge clk);
      b_req_valid = 1'b0;
      e = sb.pop_front();
      checks++;
      if (b_resp_valid !== 1'b1 || b_resp_instr !== e.instr || b_resp_err !== e.err) begin
        errors++;
        $display("FAIL zw%0d resp: valid=%b instr=%h err=%b want 1 %h %b",
                 k, b_resp_valid, b_resp_instr, b_resp_err, e.instr, e.err);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    b_req_valid = 1'b0; b_req_addr = '0; b_resp_ready = 1'b1;
    b_load_en = 1'b0; b_load_addr = '0; b_load_data = '0;
    test_reset();
    test_load_fetch();
    test_backpressure();
    test_errors();
    test_reset_abort();
    test_collision();
    test_zero_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
